// File: rtl/mult16_seq_pkg.sv
// mult16_seq_pkg: shared constants and the controller state type for the
// sequential 16x16 multiplier.
package mult16_seq_pkg;

  localparam int MUL_W    = 16;
  localparam int MUL_ITER = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // 2'd3 has no name on purpose; the controller treats it as a recovery path to IDLE.
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/mult16_seq_if.sv
// mult16_seq_if: start/busy/done handshake plus operands and product.
//   master : requester (drives start, a, b; observes busy, done, product)
//   slave  : multiplier (observes start, a, b; drives busy, done, product)
interface mult16_seq_if;
  import mult16_seq_pkg::*;

  logic                 start;
  logic [MUL_W-1:0]     a;
  logic [MUL_W-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*MUL_W-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mult16_seq_adder.sv
// LCUAdder16: 16-bit carry-lookahead adder built from four 4-bit groups and a
// lookahead carry unit across the groups.
//   a, b : addends          cin  : carry in
//   sum  : 16-bit sum       cout : carry out
//   pg   : group propagate  gg   : group generate (independent of cin)
module LCUAdder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        pg,
  output logic        gg
);

  logic [15:0] p, g, c;
  logic [3:0]  grp_p, grp_g;
  logic [4:0]  grp_c;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    grp_p = '0;
    grp_g = '0;
    for (int j = 0; j < 4; j++) begin
      grp_p[j] = &p[4*j +: 4];
      grp_g[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
  end

  assign pg = &grp_p;
  assign gg = grp_g[3]
            | (grp_p[3] & grp_g[2])
            | (grp_p[3] & grp_p[2] & grp_g[1])
            | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);

  assign grp_c[0] = cin;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
  assign grp_c[4] = gg | (pg & cin);

  // Bit carries inside each group start from the lookahead group carry.
  always_comb begin
    logic carry;
    c = '0;
    carry = 1'b0;
    for (int j = 0; j < 4; j++) begin
      carry = grp_c[j];
      for (int i = 0; i < 4; i++) begin
        c[4*j+i] = carry;
        carry    = g[4*j+i] | (p[4*j+i] & carry);
      end
    end
  end

  assign sum  = p ^ c;
  assign cout = grp_c[4];

endmodule

// File: rtl/mult16_seq.sv
// mult16_seq: unsigned 16x16->32 shift-and-add multiplier. One conditional add
// through LCUAdder16 per cycle for 16 cycles, then a one-cycle DONE.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of mult16_seq_if (start/a/b in; busy/done/product out)
//
// state | meaning
// IDLE  | waiting for start; product holds last result
// RUN   | one add-and-shift per cycle, 16 cycles
// DONE  | one-cycle done pulse; start here begins the next run
module mult16_seq
  import mult16_seq_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  mult16_seq_if.slave  bus
);

  state_t           state_q, state_d;
  logic [MUL_W-1:0] m, hi, lo;
  logic [4:0]       cnt;
  logic             accept;
  logic             last_iter;

  logic [MUL_W-1:0] addend;
  logic [MUL_W-1:0] sum;
  logic             cout;

  assign addend = m & {MUL_W{lo[0]}};

  LCUAdder16 u_adder (
    .a    (hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout),
    .pg   (),
    .gg   ()
  );

  assign last_iter = (cnt == 5'(MUL_ITER - 1));
  assign accept    = bus.start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      m       <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        m   <= bus.a;
        hi  <= '0;
        lo  <= bus.b;
        cnt <= '0;
      end else if (state_q == RUN) begin
        // 33-bit right shift of {cout, sum, lo}: the carry lands in hi[15].
        {hi, lo} <= {cout, sum, lo[MUL_W-1:1]};
        cnt      <= cnt + 5'd1;
      end
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = {hi, lo};

endmodule

// File: tb/tb_mult16_seq.sv
module tb_mult16_seq;

  logic clk;
  logic reset;
  int   checks;
  int   passed;

  mult16_seq_if bus ();

  mult16_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle start; returns #1 after the accepting edge with start low.
  task automatic launch(input logic [15:0] av, input logic [15:0] bv);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    step();
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
  endtask

  // Edges until done is seen, or -1 when the bound runs out.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (bus.done === 1'b1) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.a     = 16'h0009;
    bus.b     = 16'h0009;
    step();
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_flags busy=%b done=%b want 0 0", bus.busy, bus.done);
    else passed++;
    checks++;
    if (bus.product !== 32'h0) $display("FAIL reset_product got %h want 00000000", bus.product);
    else passed++;
    reset     = 1'b0;
    bus.start = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_start_dropped busy=%b want 0", bus.busy);
    else passed++;
  endtask

  task automatic test_basic();
    int bad;
    launch(16'd3, 16'd5);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) $display("FAIL basic_busy_rise busy=%b done=%b want 1 0", bus.busy, bus.done);
    else passed++;
    bad = 0;
    for (int n = 1; n < 16; n++) begin
      step();
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL basic_busy_window got %0d bad cycles want 0", bad);
    else passed++;
    step();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) $display("FAIL basic_done_edge done=%b busy=%b want 1 0", bus.done, bus.busy);
    else passed++;
    checks++;
    if (bus.product !== 32'h0000000F) $display("FAIL basic_product got %h want 0000000f", bus.product);
    else passed++;
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL basic_done_pulse done=%b busy=%b want 0 0", bus.done, bus.busy);
    else passed++;
    repeat (3) step();
    checks++;
    if (bus.product !== 32'h0000000F) $display("FAIL basic_hold got %h want 0000000f", bus.product);
    else passed++;
  endtask

  task automatic test_carry();
    int cyc;
    launch(16'hFFFF, 16'hFFFF);
    wait_done(cyc);
    checks++;
    if (cyc != 16) $display("FAIL carry_latency got %0d want 16", cyc);
    else passed++;
    checks++;
    if (bus.product !== 32'hFFFE0001) $display("FAIL carry_product got %h want fffe0001", bus.product);
    else passed++;
    step();
  endtask

  task automatic test_zero();
    int cyc;
    launch(16'h1234, 16'h0000);
    wait_done(cyc);
    checks++;
    if (cyc != 16) $display("FAIL zero_latency got %0d want 16", cyc);
    else passed++;
    checks++;
    if (bus.product !== 32'h0) $display("FAIL zero_product got %h want 00000000", bus.product);
    else passed++;
    step();
  endtask

  task automatic test_ignore_busy();
    int cyc;
    launch(16'd2, 16'd3);
    repeat (4) step();
    bus.start = 1'b1;
    bus.a     = 16'd7;
    bus.b     = 16'd7;
    step();
    bus.start = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc < 0 || cyc + 5 != 16) $display("FAIL ignore_latency got %0d want 16", cyc < 0 ? cyc : cyc + 5);
    else passed++;
    checks++;
    if (bus.product !== 32'd6) $display("FAIL ignore_product got %h want 00000006", bus.product);
    else passed++;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL ignore_no_restart busy=%b done=%b want 0 0", bus.busy, bus.done);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    launch(16'h0011, 16'h0101);
    wait_done(cyc);
    checks++;
    if (cyc != 16 || bus.product !== 32'h00001111) $display("FAIL b2b_first cyc=%0d product=%h want 16 00001111", cyc, bus.product);
    else passed++;
    launch(16'h00FF, 16'h0100);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) $display("FAIL b2b_restart busy=%b done=%b want 1 0", bus.busy, bus.done);
    else passed++;
    wait_done(cyc);
    checks++;
    if (cyc != 16) $display("FAIL b2b_second_latency got %0d want 16", cyc);
    else passed++;
    checks++;
    if (bus.product !== 32'h0000FF00) $display("FAIL b2b_second_product got %h want 0000ff00", bus.product);
    else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    int cyc;
    launch(16'h1234, 16'h5678);
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL midreset_flags busy=%b done=%b want 0 0", bus.busy, bus.done);
    else passed++;
    checks++;
    if (bus.product !== 32'h0) $display("FAIL midreset_product got %h want 00000000", bus.product);
    else passed++;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL midreset_idle busy=%b done=%b want 0 0", bus.busy, bus.done);
    else passed++;
    launch(16'h8000, 16'h0002);
    wait_done(cyc);
    checks++;
    if (cyc != 16 || bus.product !== 32'h00010000) $display("FAIL midreset_after cyc=%0d product=%h want 16 00010000", cyc, bus.product);
    else passed++;
    step();
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    step();
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
